// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM states, quarter-phase encodings and ACK/NACK line levels.
package i2c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAddr,
        StAack,
        StData,
        StDack,
        StStop
    } i2c_state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period tick generator: one-clk tick every CLK_DIV enabled, non-held clocks.
module i2c_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic hold,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q;

    // hold freezes the count so a stretched phase keeps its remaining length
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!en) begin
            cnt_q <= '0;
        end else if (!hold) begin
            cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

    assign tick = en && !hold && (cnt_q == CntMax);

endmodule

// File: rtl/i2c_master_tx.sv
// I2C master write engine: START, address+W, FIFO bytes while ACKed and available, STOP.
// Optional SCL clock stretching is enabled by defining I2C_CLK_STRETCH_EN.
module i2c_master_tx
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter logic [6:0]  SLAVE_ADDR = 7'h42,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_rd_en,
    output logic              scl_oe,
    input  logic              scl_i,
    output logic              sda_oe,
    input  logic              sda_i,
    output logic              o_busy,
    output logic              o_nack
);

    localparam logic [DATA_W-1:0] AddrByte = DATA_W'({SLAVE_ADDR, 1'b0});

    i2c_state_e        state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              ack_q, ack_d;
    logic              nack_q, nack_d;
    logic              tick;
    logic              hold;

`ifdef I2C_CLK_STRETCH_EN
    logic stretch_pt;
    // SCL has just been released; wait for the pad to actually go high
    assign stretch_pt = ((state_q inside {StAddr, StAack, StData, StDack}) && (phase_q == Q2)) ||
                        ((state_q == StStop) && (phase_q == Q1));
    assign hold = stretch_pt && !scl_i;
`else
    logic unused_scl_i;
    assign unused_scl_i = scl_i;
    assign hold = 1'b0;
`endif

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state_q != StIdle),
        .hold    (hold),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            phase_q   <= Q0;
            bit_cnt_q <= 3'd0;
            shreg_q   <= '0;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ack_d     = ack_q;
        nack_d    = nack_q;
        o_rd_en   = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_valid) begin
                    state_d = StStart;
                    phase_d = Q0;
                    nack_d  = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (phase_q == Q2) begin
                        state_d   = StAddr;
                        phase_d   = Q0;
                        shreg_d   = AddrByte;
                        bit_cnt_d = 3'd7;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            StAddr, StData: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == Q3) begin
                        if (bit_cnt_q == 3'd0) begin
                            state_d = (state_q == StAddr) ? StAack : StDack;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
            end
            StAack, StDack: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == Q2) begin
                        ack_d = (sda_i == ACK);
                        if (sda_i == NACK) begin
                            nack_d = 1'b1;
                        end
                    end
                    if (phase_q == Q3) begin
                        // the pop and the capture happen in the same clk
                        if (ack_q && i_valid) begin
                            state_d   = StData;
                            o_rd_en   = 1'b1;
                            shreg_d   = i_data;
                            bit_cnt_d = 3'd7;
                        end else begin
                            state_d = StStop;
                        end
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == Q3) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            StStart: begin
                sda_oe = 1'b1;
                scl_oe = (phase_q == Q2);
            end
            StAddr, StData: begin
                sda_oe = !shreg_q[DATA_W-1];
                scl_oe = (phase_q == Q0) || (phase_q == Q1);
            end
            StAack, StDack: begin
                scl_oe = (phase_q == Q0) || (phase_q == Q1);
            end
            StStop: begin
                scl_oe = (phase_q == Q0);
                sda_oe = (phase_q == Q0) || (phase_q == Q1);
            end
            default: ;
        endcase
    end

    assign o_busy = (state_q != StIdle);
    assign o_nack = nack_q;

endmodule
